mem_bus_controller: RTL and testbench

- Sequences every external bus cycle for the CPU core.
- Takes microcode read/write requests and drives addr/rd/wr/mem_io/data_out with setup, strobe, wait-state and hold phases.
- Arbitrates the external bus between the CPU and an external DMA master, and implements the HALT state with interrupt wake-up.
- Sits between the microcode sequencer / MAR / MDR and the chip pads.

---
 rtl/mem_bus_controller_pkg.sv | 18 +
 rtl/mem_bus_controller_sync_ff.sv | 24 ++
 rtl/mem_bus_controller.sv | 192 +++++++++++++++++++
 tb/tb_mem_bus_controller.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_controller_pkg.sv
// Shared types and constants for the external bus controller.
// Holds the bus-cycle state encoding and default timing parameters.
package pa_bus;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD,
      DMA,
      HALT
   } e_bus_state;

   localparam logic [7:0]  BUS_ERR_DATA     = 8'hFF;
   localparam int unsigned SETUP_CYCLES_DEF = 1;
   localparam int unsigned MAX_WAIT_DEF     = 255;

endpackage

// File: rtl/mem_bus_controller_sync_ff.sv
// Multi-stage flop synchronizer for a single asynchronous input.
// All stages clear to 0 on the asynchronous reset.
module sync_ff #(
   parameter int unsigned DEPTH = 2
) (
   input  logic clk,
   input  logic arst,
   input  logic d,
   output logic q
);

   logic [DEPTH-1:0] chain;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         chain <= '0;
      end else begin
         chain <= {chain[DEPTH-2:0], d};
      end
   end

   assign q = chain[DEPTH-1];

endmodule

// File: rtl/mem_bus_controller.sv
// External bus cycle sequencer: setup/strobe/wait/hold phasing for CPU
// accesses, DMA bus hand-off and the HALT state with interrupt wake-up.
module mem_bus_controller
   import pa_bus::*;
#(
   parameter int unsigned SETUP_CYCLES = SETUP_CYCLES_DEF,
   parameter int unsigned MAX_WAIT     = MAX_WAIT_DEF,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic        clk,
   input  logic        arst,
   input  logic        cpu_req,
   input  logic        cpu_wr,
   input  logic        cpu_mem_io,
   input  logic [21:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_halt_req,
   input  logic        int_pending,
   input  logic        dma_req,
   input  logic        pad_wait,
   input  logic [7:0]  data_bus_in,
   output logic [7:0]  cpu_rdata,
   output logic        cpu_done,
   output logic        cpu_stall,
   output logic        bus_err,
   output logic [21:0] addr,
   output logic [7:0]  data_out,
   output logic        data_oe,
   output logic        bus_oe,
   output logic        rd,
   output logic        wr,
   output logic        mem_io,
   output logic        halt,
   output logic        dma_ack
);

   localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYCLES - 1);
   localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

   e_bus_state  state_q, state_d;
   logic [21:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        wr_q, wr_d;
   logic        mem_io_q, mem_io_d;
   logic [3:0]  setup_cnt_q, setup_cnt_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        dma_block_q, dma_block_d;
   logic        from_halt_q, from_halt_d;
   logic        dma_sync;

   sync_ff #(
      .DEPTH (SYNC_STAGES)
   ) u_dma_sync (
      .clk  (clk),
      .arst (arst),
      .d    (dma_req),
      .q    (dma_sync)
   );

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         wr_q        <= 1'b0;
         mem_io_q    <= 1'b0;
         setup_cnt_q <= '0;
         wait_cnt_q  <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         dma_block_q <= 1'b0;
         from_halt_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wr_q        <= wr_d;
         mem_io_q    <= mem_io_d;
         setup_cnt_q <= setup_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         dma_block_q <= dma_block_d;
         from_halt_q <= from_halt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wr_d        = wr_q;
      mem_io_d    = mem_io_q;
      setup_cnt_d = setup_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      dma_block_d = dma_block_q;
      from_halt_d = from_halt_q;

      unique case (state_q)
         IDLE: begin
            // DMA outranks the CPU unless the CPU is owed a cycle after the last grant
            if (dma_sync && !dma_block_q) begin
               state_d     = DMA;
               from_halt_d = 1'b0;
            end else if (cpu_req) begin
               state_d     = SETUP;
               addr_d      = cpu_addr;
               wdata_d     = cpu_wdata;
               wr_d        = cpu_wr;
               mem_io_d    = cpu_mem_io;
               setup_cnt_d = '0;
               dma_block_d = 1'b0;
            end else if (cpu_halt_req) begin
               state_d = HALT;
            end
         end

         SETUP: begin
            if (setup_cnt_q == SETUP_LAST) begin
               state_d     = STROBE;
               setup_cnt_d = '0;
               wait_cnt_d  = '0;
            end else begin
               setup_cnt_d = setup_cnt_q + 4'd1;
            end
         end

         STROBE: begin
            if (pad_wait) begin
               if (wait_cnt_q == WAIT_LIMIT) begin
                  state_d = HOLD;
                  err_d   = 1'b1;
                  rdata_d = BUS_ERR_DATA;
               end else begin
                  wait_cnt_d = wait_cnt_q + 8'd1;
               end
            end else begin
               state_d = HOLD;
               if (!wr_q) begin
                  rdata_d = data_bus_in;
               end
            end
         end

         HOLD: begin
            state_d = IDLE;
            err_d   = 1'b0;
         end

         DMA: begin
            if (!dma_sync) begin
               state_d = from_halt_q ? HALT : IDLE;
               if (cpu_req) begin
                  dma_block_d = 1'b1;
               end
            end
         end

         HALT: begin
            if (dma_sync) begin
               state_d     = DMA;
               from_halt_d = 1'b1;
            end else if (int_pending) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cpu_done  = (state_q == HOLD);
      bus_err   = (state_q == HOLD) && err_q;
      rd        = (state_q == STROBE) && !wr_q;
      wr        = (state_q == STROBE) && wr_q;
      data_oe   = wr_q && ((state_q == SETUP) || (state_q == STROBE) || (state_q == HOLD));
      bus_oe    = (state_q != DMA);
      dma_ack   = (state_q == DMA);
      halt      = (state_q == HALT) || ((state_q == DMA) && from_halt_q);
      cpu_stall = cpu_req && !cpu_done;
      addr      = addr_q;
      data_out  = wdata_q;
      mem_io    = mem_io_q;
      cpu_rdata = rdata_q;
   end

endmodule

// File: tb/tb_mem_bus_controller.sv
// Directed bench for mem_bus_controller: read, waited write, wait timeout,
// DMA arbitration, HALT with DMA and wake-up, and reset during a strobe.
module tb_mem_bus_controller;

   logic        clk = 1'b0;
   logic        arst;
   logic        cpu_req, cpu_wr, cpu_mem_io, cpu_halt_req, int_pending;
   logic        dma_req, pad_wait;
   logic [21:0] cpu_addr;
   logic [7:0]  cpu_wdata, data_bus_in;
   logic [7:0]  cpu_rdata, data_out;
   logic [21:0] addr;
   logic        cpu_done, cpu_stall, bus_err, data_oe, bus_oe;
   logic        rd, wr, mem_io, halt, dma_ack;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_bus_controller #(
      .SETUP_CYCLES (1),
      .MAX_WAIT     (4),
      .SYNC_STAGES  (2)
   ) dut (
      .clk          (clk),
      .arst         (arst),
      .cpu_req      (cpu_req),
      .cpu_wr       (cpu_wr),
      .cpu_mem_io   (cpu_mem_io),
      .cpu_addr     (cpu_addr),
      .cpu_wdata    (cpu_wdata),
      .cpu_halt_req (cpu_halt_req),
      .int_pending  (int_pending),
      .dma_req      (dma_req),
      .pad_wait     (pad_wait),
      .data_bus_in  (data_bus_in),
      .cpu_rdata    (cpu_rdata),
      .cpu_done     (cpu_done),
      .cpu_stall    (cpu_stall),
      .bus_err      (bus_err),
      .addr         (addr),
      .data_out     (data_out),
      .data_oe      (data_oe),
      .bus_oe       (bus_oe),
      .rd           (rd),
      .wr           (wr),
      .mem_io       (mem_io),
      .halt         (halt),
      .dma_ack      (dma_ack)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      arst = 1'b1;
      cpu_req = 1'b0; cpu_wr = 1'b0; cpu_mem_io = 1'b0; cpu_halt_req = 1'b0;
      int_pending = 1'b0; dma_req = 1'b0; pad_wait = 1'b0;
      cpu_addr = '0; cpu_wdata = '0; data_bus_in = '0;
      tick(); tick();

      chk("rst_addr",    32'(addr), 32'h0);
      chk("rst_dout",    32'(data_out), 32'h0);
      chk("rst_rdata",   32'(cpu_rdata), 32'h0);
      chk("rst_bus_oe",  32'(bus_oe), 32'h1);
      chk("rst_strobes", 32'({rd, wr, data_oe, cpu_done, bus_err, halt, dma_ack, mem_io}), 32'h0);
      arst = 1'b0;
      tick();

      // Read 0x012345, memory space, no wait
      cpu_req = 1'b1; cpu_wr = 1'b0; cpu_mem_io = 1'b1; cpu_addr = 22'h012345;
      data_bus_in = 8'hA5;
      tick();
      chk("rd_setup_rd",    32'(rd), 32'h0);
      chk("rd_setup_addr",  32'(addr), 32'h012345);
      chk("rd_setup_memio", 32'(mem_io), 32'h1);
      chk("rd_setup_stall", 32'(cpu_stall), 32'h1);
      chk("rd_setup_oe",    32'(data_oe), 32'h0);
      tick();
      chk("rd_strobe_rd",   32'(rd), 32'h1);
      chk("rd_strobe_done", 32'(cpu_done), 32'h0);
      tick();
      chk("rd_hold_rd",     32'(rd), 32'h0);
      chk("rd_hold_done",   32'(cpu_done), 32'h1);
      chk("rd_hold_stall",  32'(cpu_stall), 32'h0);
      chk("rd_hold_err",    32'(bus_err), 32'h0);
      chk("rd_rdata",       32'(cpu_rdata), 32'hA5);
      cpu_req = 1'b0;
      tick();
      chk("rd_idle_done",   32'(cpu_done), 32'h0);

      // Write 0x000010 = 0x3C with three wait edges
      cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 22'h000010; cpu_wdata = 8'h3C;
      pad_wait = 1'b1;
      tick();
      chk("wr_setup_oe",   32'(data_oe), 32'h1);
      chk("wr_setup_dout", 32'(data_out), 32'h3C);
      chk("wr_setup_wr",   32'(wr), 32'h0);
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("wr_strobe_wr",   32'(wr), 32'h1);
         chk("wr_strobe_oe",   32'(data_oe), 32'h1);
         chk("wr_strobe_done", 32'(cpu_done), 32'h0);
         if (i == 3) pad_wait = 1'b0;
         tick();
      end
      chk("wr_hold_wr",   32'(wr), 32'h0);
      chk("wr_hold_done", 32'(cpu_done), 32'h1);
      chk("wr_hold_err",  32'(bus_err), 32'h0);
      chk("wr_hold_oe",   32'(data_oe), 32'h1);
      cpu_req = 1'b0;
      tick();
      chk("wr_idle_done", 32'(cpu_done), 32'h0);
      chk("wr_idle_oe",   32'(data_oe), 32'h0);

      // Read with pad_wait stuck: 1 strobe cycle + 4 wait cycles, then abort
      cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 22'h000020; data_bus_in = 8'h5A;
      pad_wait = 1'b1;
      tick();
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("to_strobe_rd",  32'(rd), 32'h1);
         chk("to_strobe_err", 32'(bus_err), 32'h0);
         tick();
      end
      chk("to_hold_done",  32'(cpu_done), 32'h1);
      chk("to_hold_err",   32'(bus_err), 32'h1);
      chk("to_hold_rdata", 32'(cpu_rdata), 32'hFF);
      cpu_req = 1'b0; pad_wait = 1'b0;
      tick();
      chk("to_idle_err",  32'(bus_err), 32'h0);
      chk("to_idle_done", 32'(cpu_done), 32'h0);

      // DMA and CPU requests presented to IDLE together: DMA wins
      dma_req = 1'b1;
      tick();
      chk("dma_sync1_ack", 32'(dma_ack), 32'h0);
      tick();
      chk("dma_sync2_ack", 32'(dma_ack), 32'h0);
      cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 22'h000030; data_bus_in = 8'h77;
      tick();
      chk("dma_ack",     32'(dma_ack), 32'h1);
      chk("dma_bus_oe",  32'(bus_oe), 32'h0);
      chk("dma_rd",      32'(rd), 32'h0);
      chk("dma_stall",   32'(cpu_stall), 32'h1);
      tick();
      chk("dma_hold_ack", 32'(dma_ack), 32'h1);
      dma_req = 1'b0;
      tick();
      dma_req = 1'b1;
      tick();
      chk("dma_tail_ack", 32'(dma_ack), 32'h1);
      tick();
      chk("dma_rel_ack",  32'(dma_ack), 32'h0);
      chk("dma_rel_oe",   32'(bus_oe), 32'h1);
      tick();
      chk("blk_setup_ack",  32'(dma_ack), 32'h0);
      chk("blk_setup_addr", 32'(addr), 32'h000030);
      tick();
      chk("blk_strobe_rd",  32'(rd), 32'h1);
      tick();
      chk("blk_hold_done",  32'(cpu_done), 32'h1);
      chk("blk_rdata",      32'(cpu_rdata), 32'h77);
      cpu_req = 1'b0;
      tick();
      chk("blk_idle_ack",   32'(dma_ack), 32'h0);
      tick();
      chk("dma2_ack",       32'(dma_ack), 32'h1);
      dma_req = 1'b0;
      tick(); tick(); tick();
      chk("dma2_rel_ack",   32'(dma_ack), 32'h0);
      chk("dma2_rel_oe",    32'(bus_oe), 32'h1);

      // HALT, DMA while halted, wake-up deferred until after DMA
      cpu_halt_req = 1'b1;
      tick();
      chk("halt_enter", 32'(halt), 32'h1);
      cpu_halt_req = 1'b0;
      dma_req = 1'b1;
      tick(); tick();
      chk("halt_wait_ack", 32'(dma_ack), 32'h0);
      tick();
      chk("halt_dma_ack",  32'(dma_ack), 32'h1);
      chk("halt_dma_halt", 32'(halt), 32'h1);
      int_pending = 1'b1; dma_req = 1'b0;
      tick();
      chk("halt_dma_int_ack", 32'(dma_ack), 32'h1);
      tick();
      chk("halt_dma_int_halt", 32'(halt), 32'h1);
      tick();
      chk("halt_back_ack",  32'(dma_ack), 32'h0);
      chk("halt_back_halt", 32'(halt), 32'h1);
      tick();
      chk("halt_wake", 32'(halt), 32'h0);
      int_pending = 1'b0;
      tick();

      // Reset asserted during the strobe of a write
      cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 22'h3FFFFF; cpu_wdata = 8'h81;
      tick(); tick();
      chk("rst_mid_wr_pre", 32'(wr), 32'h1);
      arst = 1'b1;
      #1;
      chk("rst_mid_wr",   32'(wr), 32'h0);
      chk("rst_mid_oe",   32'(data_oe), 32'h0);
      chk("rst_mid_addr", 32'(addr), 32'h0);
      chk("rst_mid_dout", 32'(data_out), 32'h0);
      tick();
      chk("rst_mid_done", 32'(cpu_done), 32'h0);
      arst = 1'b0;
      tick();
      chk("restart_setup_addr", 32'(addr), 32'h3FFFFF);
      chk("restart_setup_wr",   32'(wr), 32'h0);
      tick();
      chk("restart_strobe_wr",  32'(wr), 32'h1);
      tick();
      chk("restart_hold_done",  32'(cpu_done), 32'h1);
      chk("restart_hold_dout",  32'(data_out), 32'h81);
      cpu_req = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
